// File: rtl/nubus_slave.sv
// NuBus slave responder: decodes slot/superslot starts, turns each accepted
// transfer into one local memory request and acks it back on the bus.
module nubus_slave #(
  parameter int unsigned TIMEOUT_CLOCKS = 255,
  parameter bit          SUPERSLOT_EN   = 1'b1
) (
  input  logic               nub_clkn,
  input  logic               nub_resetn,
  input  logic [3:0]         nub_idn,
  input  logic               nub_startn,
  inout  wire logic [31:0]   nub_adn,
  inout  wire logic          nub_tm1n,
  inout  wire logic          nub_tm0n,
  inout  wire logic          nub_ackn,
  output logic               mem_valid,
  output logic [3:0]         mem_write,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  output logic               mem_myslot,
  output logic               mem_myexp
);

  localparam int unsigned    CW  = 8;
  localparam logic [CW-1:0]  TMO = CW'(TIMEOUT_CLOCKS);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_MEM, S_ACK} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [3:0]     write_q, write_d;
  logic [31:0]    addr_q, addr_d;
  logic           slot_q, slot_d;
  logic           exp_q, exp_d;
  logic [1:0]     status_q, status_d;
  logic           rd_q, rd_d;

  // Falling-edge samples of the bus and of the memory handshake
  logic           start_q;
  logic [31:0]    a_q;
  logic           tm1_q, tm0_q;
  logic           rdy_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q;

  logic [3:0]     slot_id;
  logic           slot_hit, sup_hit, blk;
  logic [3:0]     strb;

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      start_q <= 1'b0;
      a_q     <= '0;
      tm1_q   <= 1'b0;
      tm0_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      start_q <= (state_q == S_IDLE) && !nub_startn;
      if (state_q == S_IDLE) begin
        a_q   <= ~nub_adn;
        tm1_q <= ~nub_tm1n;
        tm0_q <= ~nub_tm0n;
      end
      rdy_q <= (state_q == S_MEM) && mem_ready;
      if (state_q == S_DATA) wdata_q <= ~nub_adn;
      if ((state_q == S_MEM) && mem_ready) rdata_q <= mem_rdata;
    end
  end

  // Address decode; slot IDs 0 and F have no superslot space
  assign slot_id  = ~nub_idn;
  assign slot_hit = (a_q[31:24] == {4'hF, slot_id});
  assign sup_hit  = SUPERSLOT_EN && (a_q[31:28] == slot_id) &&
                    (slot_id != 4'h0) && (slot_id != 4'hF);

  always_comb begin
    blk  = 1'b0;
    strb = 4'b0000;
    if (tm0_q) begin
      strb = 4'b0001 << a_q[1:0];
    end else begin
      case (a_q[1:0])
        2'b00:   strb = 4'b1111;
        2'b10:   strb = 4'b0011;
        2'b11:   strb = 4'b1100;
        default: blk  = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    write_d  = write_q;
    addr_d   = addr_q;
    slot_d   = slot_q;
    exp_d    = exp_q;
    status_d = status_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start_q && (slot_hit || sup_hit)) begin
          rd_d = !tm1_q;
          if (blk) begin
            state_d  = S_ACK;
            status_d = ST_ERR;
          end else begin
            addr_d  = {a_q[31:2], 2'b00};
            write_d = tm1_q ? strb : 4'b0000;
            slot_d  = slot_hit;
            exp_d   = sup_hit;
            cnt_d   = '0;
            if (tm1_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_MEM;
              valid_d = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        state_d = S_MEM;
        valid_d = 1'b1;
        cnt_d   = '0;
      end
      S_MEM: begin
        if (rdy_q) begin
          state_d  = S_ACK;
          status_d = ST_OK;
          valid_d  = 1'b0;
        end else if (cnt_q == TMO) begin
          state_d  = S_ACK;
          status_d = ST_TMO;
          valid_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        slot_d  = 1'b0;
        exp_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      write_q  <= '0;
      addr_q   <= '0;
      slot_q   <= 1'b0;
      exp_q    <= 1'b0;
      status_q <= ST_OK;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      slot_q   <= slot_d;
      exp_q    <= exp_d;
      status_q <= status_d;
      rd_q     <= rd_d;
    end
  end

  assign mem_valid  = valid_q;
  assign mem_write  = write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_myslot = slot_q;
  assign mem_myexp  = exp_q;

  // Bus lines are only driven during the single ACK cycle
  assign nub_ackn = (state_q == S_ACK) ? 1'b0 : 1'bz;
  assign nub_tm1n = (state_q == S_ACK) ? status_q[1] : 1'bz;
  assign nub_tm0n = (state_q == S_ACK) ? status_q[0] : 1'bz;
  assign nub_adn  = ((state_q == S_ACK) && rd_q) ? ~rdata_q : {32{1'bz}};

endmodule

// File: tb/tb_nubus_slave.sv
// Directed bench for nubus_slave: a bus master task, a small memory responder
// and hand-computed expectations.
module tb_nubus_slave;

  logic        nub_clkn = 1'b0;
  logic        nub_resetn;
  logic [3:0]  idn0, idn1;
  logic        startn;
  tri1 [31:0]  nub_adn;
  tri1         nub_tm1n, nub_tm0n, nub_ackn;

  logic [31:0] tb_adn;
  logic        tb_adn_en;
  logic        tb_tm1n, tb_tm0n, tb_tm_en;

  assign nub_adn  = tb_adn_en ? tb_adn : {32{1'bz}};
  assign nub_tm1n = tb_tm_en ? tb_tm1n : 1'bz;
  assign nub_tm0n = tb_tm_en ? tb_tm0n : 1'bz;

  logic        valid0, myslot0, myexp0, ready0;
  logic [3:0]  write0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        valid1, myslot1, myexp1, ready1;
  logic [3:0]  write1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata1 = 32'h1234ABCD;

  nubus_slave #(.TIMEOUT_CLOCKS(4), .SUPERSLOT_EN(1'b1)) u_dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_idn(idn0), .nub_startn(startn),
    .nub_adn(nub_adn), .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n), .nub_ackn(nub_ackn),
    .mem_valid(valid0), .mem_write(write0), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_rdata(rdata0), .mem_ready(ready0), .mem_myslot(myslot0), .mem_myexp(myexp0)
  );

  nubus_slave #(.SUPERSLOT_EN(1'b0)) u_dut_nosup (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_idn(idn1), .nub_startn(startn),
    .nub_adn(nub_adn), .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n), .nub_ackn(nub_ackn),
    .mem_valid(valid1), .mem_write(write1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .mem_ready(ready1), .mem_myslot(myslot1), .mem_myexp(myexp1)
  );

  always #5 nub_clkn = ~nub_clkn;

  int n_cmp = 0;
  int n_err = 0;

  // Memory responder for the main instance
  logic [31:0] mem [16] = '{default: 32'h0};
  int          wait_clks;
  bit          hold_rdy;
  int          wcnt = 0;
  int          vcnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_write;
  logic        cap_slot, cap_exp;

  initial ready0 = 1'b0;
  initial rdata0 = 32'h0;

  always @(posedge nub_clkn) begin
    #1;
    if (valid0) vcnt++;
    if (valid0 && !hold_rdy && !ready0) begin
      if (wcnt >= wait_clks) begin
        ready0    = 1'b1;
        cap_addr  = addr0;
        cap_write = write0;
        cap_wdata = wdata0;
        cap_slot  = myslot0;
        cap_exp   = myexp0;
        for (int b = 0; b < 4; b++)
          if (write0[b]) mem[addr0[5:2]][8*b +: 8] = wdata0[8*b +: 8];
        rdata0 = mem[addr0[5:2]];
      end else begin
        wcnt++;
      end
    end else begin
      ready0 = 1'b0;
      wcnt   = 0;
    end
  end

  // Always-ready responder for the superslot-disabled instance
  int   v1cnt = 0;
  logic cap1_slot;
  initial ready1 = 1'b0;
  always @(posedge nub_clkn) begin
    #1;
    ready1 = valid1 && !ready1;
    if (valid1) begin
      v1cnt++;
      cap1_slot = myslot1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transfer; waits at most budget rising edges for the ack
  task automatic xfer(input logic [31:0] addr, input logic tm1, input logic tm0,
                      input logic [31:0] wd, input int budget,
                      output logic acked, output logic [1:0] st,
                      output logic [31:0] rd, output int lat);
    acked = 1'b0; st = 2'b11; rd = '0; lat = 0;
    @(posedge nub_clkn); #1;
    startn = 1'b0; tb_adn = ~addr; tb_adn_en = 1'b1;
    tb_tm1n = ~tm1; tb_tm0n = ~tm0; tb_tm_en = 1'b1;
    @(negedge nub_clkn); #1;
    startn = 1'b1; tb_tm_en = 1'b0;
    if (tm1) tb_adn = ~wd;
    else     tb_adn_en = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge nub_clkn); #2;
      if (nub_ackn == 1'b0) begin
        acked = 1'b1;
        st    = {nub_tm1n, nub_tm0n};
        rd    = ~nub_adn;
        lat   = n;
        break;
      end
      if (n == 1) begin
        @(negedge nub_clkn); #1;
        tb_adn_en = 1'b0;
      end
    end
    tb_adn_en = 1'b0;
  endtask

  logic        acked;
  logic [1:0]  st;
  logic [31:0] rd;
  int          lat;
  int          vsnap;
  logic [31:0] byte_addr [4] = '{32'hF000000C, 32'hF0000011, 32'hF0000016, 32'hF000001B};
  logic [31:0] byte_word [4] = '{32'hF000000C, 32'hF0000010, 32'hF0000014, 32'hF0000018};
  logic [3:0]  byte_strb [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] byte_rd   [4] = '{32'h00000021, 32'h00004300, 32'h00650000, 32'h87000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nub_resetn = 1'b0; startn = 1'b1;
    tb_adn = '0; tb_adn_en = 1'b0; tb_tm1n = 1'b1; tb_tm0n = 1'b1; tb_tm_en = 1'b0;
    idn0 = ~4'h0; idn1 = ~4'hF; wait_clks = 1; hold_rdy = 1'b0;
    repeat (2) @(posedge nub_clkn);
    #2;
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_write", 32'(write0), 32'd0);
    check("rst_addr", addr0, 32'd0);
    check("rst_wdata", wdata0, 32'd0);
    check("rst_ackn", 32'(nub_ackn), 32'd1);
    check("rst_adn", nub_adn, 32'hFFFFFFFF);
    nub_resetn = 1'b1;

    // Word write then read
    xfer(32'hF0000000, 1'b1, 1'b0, 32'h87654321, 20, acked, st, rd, lat);
    check("ww_ack", 32'(acked), 32'd1);
    check("ww_status", 32'(st), 32'd0);
    check("ww_strobe", 32'(cap_write), 32'hF);
    check("ww_addr", cap_addr, 32'hF0000000);
    check("ww_wdata", cap_wdata, 32'h87654321);
    @(posedge nub_clkn); #2;
    check("ack_released", 32'(nub_ackn), 32'd1);
    check("tm_released", 32'({nub_tm1n, nub_tm0n}), 32'h3);
    xfer(32'hF0000000, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("wr_status", 32'(st), 32'd0);
    check("wr_rdata", rd, 32'h87654321);
    check("wr_strobe", 32'(cap_write), 32'd0);

    // Half 1 write and readback
    xfer(32'hF000000B, 1'b1, 1'b0, 32'h87654321, 20, acked, st, rd, lat);
    check("h1_strobe", 32'(cap_write), 32'hC);
    check("h1_addr", cap_addr, 32'hF0000008);
    xfer(32'hF0000008, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("h1_rdata", rd, 32'h87650000);

    // Byte lanes
    for (int i = 0; i < 4; i++) begin
      xfer(byte_addr[i], 1'b1, 1'b1, 32'h87654321, 20, acked, st, rd, lat);
      check("byte_strobe", 32'(cap_write), 32'(byte_strb[i]));
      xfer(byte_word[i], 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
      check("byte_rdata", rd, byte_rd[i]);
    end

    // Minimum latency with zero wait clocks
    wait_clks = 0;
    xfer(32'hF0000000, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("lat_read", 32'(lat), 32'd2);
    check("lat_read_data", rd, 32'h87654321);
    xfer(32'hF0000020, 1'b1, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("lat_write", 32'(lat), 32'd3);
    wait_clks = 1;

    // Decode with slot 3
    idn0 = ~4'h3;
    xfer(32'hF3000010, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("dec_slot_ack", 32'(acked), 32'd1);
    check("dec_slot_myslot", 32'(cap_slot), 32'd1);
    check("dec_slot_myexp", 32'(cap_exp), 32'd0);
    xfer(32'h30000010, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("dec_sup_ack", 32'(acked), 32'd1);
    check("dec_sup_myexp", 32'(cap_exp), 32'd1);
    check("dec_sup_myslot", 32'(cap_slot), 32'd0);
    vsnap = vcnt;
    xfer(32'hF4000010, 1'b0, 1'b0, 32'h0, 8, acked, st, rd, lat);
    check("dec_miss_ack", 32'(acked), 32'd0);
    check("dec_miss_valid", 32'(vcnt - vsnap), 32'd0);
    idn0 = ~4'h0;

    // Timeout
    hold_rdy = 1'b1;
    xfer(32'hF0000000, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("tmo_ack", 32'(acked), 32'd1);
    check("tmo_status", 32'(st), 32'h2);
    check("tmo_lat", 32'(lat), 32'd6);
    check("tmo_valid_drop", 32'(valid0), 32'd0);
    hold_rdy = 1'b0;

    // Block transfer is rejected with error status
    vsnap = vcnt;
    xfer(32'hF0000001, 1'b0, 1'b0, 32'h0, 8, acked, st, rd, lat);
    check("blk_ack", 32'(acked), 32'd1);
    check("blk_status", 32'(st), 32'h1);
    check("blk_lat", 32'(lat), 32'd1);
    check("blk_no_valid", 32'(vcnt - vsnap), 32'd0);

    // Superslot decode disabled
    idn0 = ~4'h7; idn1 = ~4'h3;
    vsnap = v1cnt;
    xfer(32'h30000010, 1'b0, 1'b0, 32'h0, 8, acked, st, rd, lat);
    check("nosup_ack", 32'(acked), 32'd0);
    check("nosup_valid", 32'(v1cnt - vsnap), 32'd0);
    xfer(32'hF3000010, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("nosup_slot_status", 32'(st), 32'd0);
    check("nosup_slot_rdata", rd, 32'h1234ABCD);
    check("nosup_myslot", 32'(cap1_slot), 32'd1);
    idn0 = ~4'h0; idn1 = ~4'hF;

    // Reset pulsed while in MEM
    hold_rdy = 1'b1;
    xfer(32'hF0000030, 1'b1, 1'b0, 32'hDEADBEEF, 3, acked, st, rd, lat);
    check("mid_pre_valid", 32'(valid0), 32'd1);
    check("mid_pre_wdata", wdata0, 32'hDEADBEEF);
    nub_resetn = 1'b0;
    #1;
    check("mid_valid", 32'(valid0), 32'd0);
    check("mid_write", 32'(write0), 32'd0);
    check("mid_addr", addr0, 32'd0);
    check("mid_wdata", wdata0, 32'd0);
    check("mid_myslot", 32'(myslot0), 32'd0);
    check("mid_ackn", 32'(nub_ackn), 32'd1);
    check("mid_adn", nub_adn, 32'hFFFFFFFF);
    #1;
    nub_resetn = 1'b1;
    hold_rdy = 1'b0;
    xfer(32'hF0000000, 1'b0, 1'b0, 32'h0, 20, acked, st, rd, lat);
    check("post_rst_ack", 32'(acked), 32'd1);
    check("post_rst_status", 32'(st), 32'd0);
    check("post_rst_rdata", rd, 32'h87654321);

    repeat (2) @(posedge nub_clkn);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
